// File: rtl/run_ctrl_unit.sv
// Run/load/fault controller: gates program-memory loading and PC writes, runs a watchdog,
// and collects error sources. Optional macro HALT_ON_ERROR_EN makes any error in RUN a fault.
module run_ctrl_unit #(
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   NUM_ERR    = 3,
  parameter logic [15:0]          START_WORD = 16'h1111,
  parameter int                   WDT_WIDTH  = 24,
  parameter logic [WDT_WIDTH-1:0] WDT_LIMIT  = 24'hFFFFFF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           load_valid,
  input  logic [31:0]                    load_data,
  input  logic [ADDR_WIDTH-1:0]          load_addr,
  input  logic [ADDR_WIDTH-1:0]          fetch_addr,
  input  logic                           stall_pc_write,
  input  logic                           run_finished,
  input  logic [NUM_ERR-1:0]             err_in,
  input  logic                           err_clear,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [31:0]                    mem_wdata,
  output logic                           run_flag,
  output logic                           pc_write,
  output logic                           indication,
  output logic [NUM_ERR:0]               err_cause,
  output logic                           first_err_valid,
  output logic [$clog2(NUM_ERR+1)-1:0]   first_err_id,
  output logic [31:0]                    run_cycles,
  output logic [2:0]                     state_o
);
  localparam int ID_W = $clog2(NUM_ERR+1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [WDT_WIDTH-1:0] wdt_cnt;
  logic                 start_word;
  logic                 load_open;
  logic                 wdt_fire;
  logic                 halt_err;
  logic [NUM_ERR:0]     new_err;

  assign start_word = load_valid && (load_data[15:0] == START_WORD);
  assign load_open  = (state == S_IDLE) || (state == S_LOAD) || (state == S_DONE);
  assign wdt_fire   = (state == S_RUN) && (WDT_LIMIT != '0) &&
                      (wdt_cnt == (WDT_LIMIT - 1'b1));

`ifdef HALT_ON_ERROR_EN
  assign halt_err = (state == S_RUN) && (|err_in);
`else
  assign halt_err = 1'b0;
`endif

  assign new_err = {wdt_fire, err_in};

  // The start word only switches state; it is never written into program memory.
  assign mem_we     = load_valid && load_open && !start_word;
  assign mem_addr   = mem_we ? load_addr : fetch_addr;
  assign mem_wdata  = load_data;
  assign pc_write   = stall_pc_write && run_flag;
  assign indication = (|err_in) || (|err_cause);
  assign state_o    = state;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_ERR:0] v);
    lowest_idx = '0;
    for (int i = NUM_ERR; i >= 0; i--) begin
      if (v[i]) lowest_idx = ID_W'(i);
    end
  endfunction

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_word)      state_nx = S_RUN;
        else if (load_valid) state_nx = S_LOAD;
      end
      S_LOAD:  if (start_word) state_nx = S_RUN;
      // A fault outranks a same-cycle program end.
      S_RUN: begin
        if (halt_err || wdt_fire) state_nx = S_FAULT;
        else if (run_finished)    state_nx = S_DONE;
      end
      S_FAULT: if (err_clear) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      run_flag        <= 1'b0;
      run_cycles      <= '0;
      wdt_cnt         <= '0;
      err_cause       <= '0;
      first_err_valid <= 1'b0;
      first_err_id    <= '0;
    end else begin
      state    <= state_nx;
      run_flag <= (state_nx == S_RUN);

      if (state != S_RUN && state_nx == S_RUN) begin
        run_cycles <= '0;
        wdt_cnt    <= '0;
      end else if (state == S_RUN) begin
        if (run_cycles != 32'hFFFF_FFFF) run_cycles <= run_cycles + 32'd1;
        wdt_cnt <= wdt_cnt + 1'b1;
      end

      if (err_clear) begin
        err_cause       <= '0;
        first_err_valid <= 1'b0;
        first_err_id    <= '0;
      end else begin
        err_cause <= err_cause | new_err;
        if (!first_err_valid && (|new_err)) begin
          first_err_valid <= 1'b1;
          first_err_id    <= lowest_idx(new_err);
        end
      end
    end
  end
endmodule

// File: tb/tb_run_ctrl_unit.sv
// Directed bench for run_ctrl_unit, built with a 16-cycle watchdog so expiry is reachable.
module tb_run_ctrl_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_valid;
  logic [31:0] load_data;
  logic [31:0] load_addr;
  logic [31:0] fetch_addr;
  logic        stall_pc_write;
  logic        run_finished;
  logic [2:0]  err_in;
  logic        err_clear;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        run_flag;
  logic        pc_write;
  logic        indication;
  logic [3:0]  err_cause;
  logic        first_err_valid;
  logic [1:0]  first_err_id;
  logic [31:0] run_cycles;
  logic [2:0]  state_o;

  int n_pass = 0;
  int n_total = 0;

`ifdef HALT_ON_ERROR_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  always #5 clk = ~clk;

  run_ctrl_unit #(.WDT_LIMIT(24'd16)) dut (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_data(load_data),
    .load_addr(load_addr), .fetch_addr(fetch_addr), .stall_pc_write(stall_pc_write),
    .run_finished(run_finished), .err_in(err_in), .err_clear(err_clear),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .run_flag(run_flag),
    .pc_write(pc_write), .indication(indication), .err_cause(err_cause),
    .first_err_valid(first_err_valid), .first_err_id(first_err_id),
    .run_cycles(run_cycles), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 0; load_data = 0; load_addr = 0; stall_pc_write = 0;
    run_finished = 0; err_in = 0; err_clear = 0;
  endtask

  task automatic load_word(input logic [31:0] d, input logic [31:0] a);
    load_valid = 1; load_data = d; load_addr = a;
  endtask

  initial begin
    reset_n = 0; fetch_addr = 32'h100;
    idle_inputs();
    #2;
    chk("rst_state", state_o, 0);
    chk("rst_run_flag", run_flag, 0);
    chk("rst_err_cause", err_cause, 0);
    chk("rst_first_valid", first_err_valid, 0);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_indication", indication, 0);
    #1 reset_n = 1;

    // Load three words, then the start word.
    tick();
    load_word(32'hA0A0_0001, 32'h0); #1;
    chk("ld0_we", mem_we, 1); chk("ld0_addr", mem_addr, 32'h0); chk("ld0_wdata", mem_wdata, 32'hA0A0_0001);
    tick();
    chk("ld_state", state_o, 1);
    load_word(32'hB0B0_0002, 32'h4); #1;
    chk("ld1_we", mem_we, 1); chk("ld1_addr", mem_addr, 32'h4);
    tick();
    load_word(32'hC0C0_0003, 32'h8); #1;
    chk("ld2_we", mem_we, 1); chk("ld2_addr", mem_addr, 32'h8);
    tick();
    load_word(32'h0000_1111, 32'hC); #1;
    chk("start_we", mem_we, 0); chk("start_addr", mem_addr, 32'h100);
    chk("start_run_flag", run_flag, 0);
    tick();
    idle_inputs();
    chk("run_state", state_o, 2); chk("run_flag_up", run_flag, 1); chk("run_cyc0", run_cycles, 0);
    stall_pc_write = 1; #1; chk("pc_write_hi", pc_write, 1);
    stall_pc_write = 0; #1; chk("pc_write_lo", pc_write, 0);
    tick();
    chk("run_cyc1", run_cycles, 1);
    load_word(32'hDEAD_0005, 32'h10); #1;
    chk("run_ld_ignored", mem_we, 0);
    idle_inputs();
    tick();
    chk("run_cyc2", run_cycles, 2);
    run_finished = 1;
    tick();
    run_finished = 0; stall_pc_write = 1;
    chk("done_state", state_o, 3); chk("done_run_flag", run_flag, 0);
    chk("done_cyc", run_cycles, 3); #1; chk("done_pc_write", pc_write, 0);
    tick();
    chk("done_cyc_frozen", run_cycles, 3);

    // Error pulses during a re-run without reload.
    idle_inputs(); load_word(32'h0000_1111, 32'h0);
    tick();
    idle_inputs();
    chk("rerun_state", state_o, 2); chk("rerun_cyc0", run_cycles, 0);
    err_in = 3'b110; #1;
    chk("err_ind_live", indication, 1);
    tick();
    err_in = 3'b000;
    chk("err_cause_110", err_cause, 4'b0110); chk("err_first_valid", first_err_valid, 1);
    chk("err_first_id", first_err_id, 1); chk("err_state", state_o, HALT ? 4 : 2);
    err_in = 3'b001;
    tick();
    err_in = 3'b000;
    chk("err_cause_111", err_cause, 4'b0111); chk("err_first_id_hold", first_err_id, 1);
    err_clear = 1; run_finished = 1;
    tick();
    idle_inputs();
    chk("clr_cause", err_cause, 0); chk("clr_first_valid", first_err_valid, 0);
    chk("clr_state", state_o, HALT ? 0 : 3);

    // Program end and error in the same cycle.
    load_word(32'h0000_1111, 32'h0);
    tick();
    idle_inputs();
    run_finished = 1; err_in = 3'b001;
    tick();
    idle_inputs();
    chk("both_state", state_o, HALT ? 4 : 3); chk("both_cause", err_cause, 4'b0001);
    chk("both_first_id", first_err_id, 0);
    err_clear = 1;
    tick();
    idle_inputs();
    chk("both_clr_state", state_o, HALT ? 0 : 3); chk("both_clr_cause", err_cause, 0);

    // Watchdog expiry after 16 RUN cycles.
    load_word(32'h0000_1111, 32'h0);
    tick();
    idle_inputs();
    for (int i = 0; i < 15; i++) tick();
    chk("wdt_pre_state", state_o, 2); chk("wdt_pre_cyc", run_cycles, 15);
    tick();
    chk("wdt_state", state_o, 4); chk("wdt_cause", err_cause, 4'b1000);
    chk("wdt_first_id", first_err_id, 3); chk("wdt_first_valid", first_err_valid, 1);
    chk("wdt_ind", indication, 1); chk("wdt_run_flag", run_flag, 0);
    load_word(32'h5555_0000, 32'h20); err_clear = 1; #1;
    chk("fault_ld_ignored", mem_we, 0);
    tick();
    idle_inputs();
    chk("fclr_state", state_o, 0); chk("fclr_cause", err_cause, 0);
    chk("fclr_first_valid", first_err_valid, 0); chk("fclr_first_id", first_err_id, 0);
    chk("fclr_ind", indication, 0); chk("fclr_run_flag", run_flag, 0);

    // Asynchronous reset in the middle of a run.
    load_word(32'h0000_1111, 32'h0);
    tick();
    idle_inputs();
    err_in = 3'b010;
    tick();
    err_in = 3'b000; stall_pc_write = 1; #1;
    chk("arst_pre_pc", pc_write, 1); chk("arst_pre_cause", err_cause, 4'b0010);
    reset_n = 0; #1;
    chk("arst_run_flag", run_flag, 0); chk("arst_pc", pc_write, 0);
    chk("arst_cause", err_cause, 0); chk("arst_state", state_o, 0);
    #1 reset_n = 1;
    idle_inputs();
    tick();
    load_word(32'h0000_1111, 32'h0);
    tick();
    idle_inputs();
    chk("arst_rerun_state", state_o, 2); chk("arst_rerun_cyc0", run_cycles, 0);
    tick();
    chk("arst_rerun_cyc1", run_cycles, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/run_ctrl_unit.md
Name: run_ctrl_unit

Overview:
- Parametrised run/load/fault controller for the pipelined RV32 core. Successor to the inline run_flag / indication logic in the core top level.
- Sits between the UART loader and program memory. Gates PC writes, and runs a watchdog over program execution.
- Aggregates N error sources into a sticky cause register, a first-error capture and the external indication output.

Parameters:
- ADDR_WIDTH, 32, width of the program-memory byte address.
- NUM_ERR, 3, number of error sources (decompress-fail, illegal instruction, overflow by default).
- START_WORD, 16'h1111, load_data[15:0] value that ends loading and starts the run.
- WDT_WIDTH, 24, watchdog counter width.
- WDT_LIMIT, 24'hFFFFFF, RUN cycles before watchdog fault; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- load_valid  in  1  UART word valid
- load_data  in  32  UART word
- load_addr  in  ADDR_WIDTH  UART byte address
- fetch_addr  in  ADDR_WIDTH  fetch-stage read address
- stall_pc_write  in  1  PC write enable from the stall unit
- run_finished  in  1  program end, from fetch
- err_in  in  NUM_ERR  per-cycle error pulses
- err_clear  in  1  clears the fault and all sticky state
- mem_we  out  1  program-memory write enable
- mem_addr  out  ADDR_WIDTH  program-memory address
- mem_wdata  out  32  program-memory write data
- run_flag  out  1  core running
- pc_write  out  1  gated PC write
- indication  out  1  error indication
- err_cause  out  NUM_ERR+1  sticky causes; MSB = watchdog
- first_err_valid  out  1  first-error capture valid
- first_err_id  out  $clog2(NUM_ERR+1)  index of first error (NUM_ERR = watchdog)
- run_cycles  out  32  cycles spent in RUN
- state_o  out  3  current FSM state

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. State is IDLE. All registered outputs are 0: run_flag, err_cause, first_err_valid, first_err_id, run_cycles, watchdog count.
- Start detection: a start word is load_valid=1 with load_data[15:0]==START_WORD.
- Memory port: mem_we = load_valid & (state ∈ {IDLE, LOAD, DONE}) & !start word.
  - mem_addr = mem_we ? load_addr : fetch_addr; mem_wdata = load_data.
  - Combinational, zero latency. The start word itself is never written.
- FSM states, encoded 0..4:
  - IDLE: load_valid (not start) → LOAD. Start word → RUN.
  - LOAD: start word → RUN.
  - RUN:
    - Error condition → FAULT, if HALT_ON_ERROR_EN is defined.
    - Watchdog expiry → FAULT.
    - Otherwise run_finished → DONE.
    - Priority: fault beats run_finished in the same cycle.
    - load_valid is ignored (no write).
  - DONE: load_valid (not start) → LOAD. Start word → RUN (re-run without reload).
  - FAULT: err_clear → IDLE. All load_valid is ignored while in FAULT, including the cycle err_clear is asserted.
- run_flag: registered, equal to (state==RUN). It rises the cycle after the start word is accepted and falls the cycle after run_finished or the fault.
- pc_write = stall_pc_write & run_flag, combinational.
- run_cycles:
  - Cleared to 0 on the cycle of entry into RUN.
  - Increments by 1 per RUN cycle and saturates at 32'hFFFFFFFF.
  - Holds its value in every other state.
- Watchdog:
  - Counter clears on entry into RUN and increments each RUN cycle.
  - When the counter equals WDT_LIMIT-1 while in RUN, the next state is FAULT and err_cause[NUM_ERR] is set.
  - Disabled when WDT_LIMIT==0.
- err_cause:
  - err_cause[i] |= err_in[i] every cycle, in any state.
  - Cleared only by err_clear or reset. err_clear takes priority over a same-cycle err_in.
- First-error capture:
  - first_err_valid rises on the first cycle with any error bit (including watchdog) while first_err_valid==0.
  - first_err_id = lowest set index on that cycle; the watchdog index is NUM_ERR.
  - Both hold until err_clear.
- indication = (|err_in) | (|err_cause). The live term is combinational, so indication rises in the same cycle as the pulse.
- Asynchronous reset mid-RUN: everything returns to reset values immediately. run_flag and pc_write drop without waiting for a clock edge.

Optional Feature:
- Macro: HALT_ON_ERROR_EN.
- Defined: any err_in bit set in RUN moves the FSM to FAULT next cycle. run_flag drops and the PC freezes until err_clear.
- Not defined: errors only update err_cause, first_err and indication. Execution continues in RUN, and only the watchdog can reach FAULT.

Test Plan:
- Load sequence: three words at addresses 0, 4, 8, then load_data=32'h00001111 → mem_we=1 for three cycles with correct addresses; no write for the start word; run_flag=1 one cycle later; run_cycles counts from 0.
- stall_pc_write toggled during RUN → pc_write follows it exactly. Assert run_finished → state DONE and run_flag=0 next cycle; run_cycles frozen at its value.
- With WDT_LIMIT=16 and no run_finished → FAULT after 16 RUN cycles. err_cause=4'b1000, first_err_id=3, indication=1. err_clear → IDLE with all outputs 0.
- err_in=3'b110 for one cycle in RUN → indication=1 in the same cycle; err_cause=4'b0110; first_err_id=1. A later err_in=3'b001 leaves first_err_id at 1. With HALT_ON_ERROR_EN the FSM goes to FAULT; without it, the FSM stays in RUN.
- run_finished and err_in[0] in the same cycle: with HALT_ON_ERROR_EN the FSM enters FAULT; without it, the FSM enters DONE with err_cause[0]=1.
- reset_n asserted low mid-RUN → run_flag, pc_write and err_cause drop to 0 asynchronously. After release, a start word restarts the run with run_cycles starting at 0.
